// File: rtl/pipeline_ctrl.sv
// Pipeline stage enable/flush controller for the 5-stage core: arbitrates data-memory
// freeze, EX branch redirect and load-use stall, and keeps stall/flush perf counters.
module pipeline_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_tgt,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;
  logic              redirect;
  logic              lu_stall;

  assign freeze   = (state == RUN && mem_req && !mem_ready) ||
                    (state == MEM_WAIT && !mem_ready);
  assign redirect = !rst && !freeze && ex_branch_taken;
  // Load-use is ignored under a redirect because its ID instruction is squashed anyway.
  assign lu_stall = !rst && !freeze && !ex_branch_taken && load_use_stall;
  assign redirect_pc = ex_branch_tgt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (mem_req && !mem_ready) state_next = MEM_WAIT;
      MEM_WAIT: if (mem_ready)             state_next = RUN;
      default:                             state_next = RUN;
    endcase
  end

  always_comb begin
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_en       = 1'b1;
    id_ex_flush    = 1'b0;
    ex_mem_en      = 1'b1;
    mem_wb_flush   = 1'b0;
    redirect_valid = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (freeze) begin
      // Whole pipe holds; a taken branch stays parked in EX until release.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (redirect) begin
      redirect_valid = 1'b1;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
    end else if (lu_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == RUN && mem_req && !mem_ready) begin
      wait_cnt <= '0;
    end else if (state == MEM_WAIT && !mem_ready) begin
      // Count saturates at the limit; mem_timeout stays set until reset.
      if (wait_cnt <= WAIT_LAST) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_cnt >= WAIT_LAST) mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random traffic,
// all compared against a rule-level reference model.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;
  localparam int MT    = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_use_stall, ex_branch_taken, mem_req, mem_ready;
  logic [31:0]      ex_branch_tgt;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
  logic             mem_wb_flush, redirect_valid, mem_timeout;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int errors = 0;
  int checks = 0;

  // Reference model state: waiting on memory, wait-cycle count, perf counts, sticky timeout.
  bit m_wait;
  int m_waits;
  int m_stalls;
  int m_flushes;
  bit m_tout;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .load_use_stall(load_use_stall), .ex_branch_taken(ex_branch_taken),
    .ex_branch_tgt(ex_branch_tgt), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_flush(mem_wb_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_cycles(stall_cycles),
    .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after negedge, check combinational outputs, then check state after posedge.
  task automatic step(input logic r, input logic lu, input logic bt, input logic [31:0] tgt,
                      input logic mq, input logic mr);
    bit frz, redir, lus, e_run;
    @(negedge clk);
    rst = r; load_use_stall = lu; ex_branch_taken = bt; ex_branch_tgt = tgt;
    mem_req = mq; mem_ready = mr;
    #1;
    frz   = m_wait ? !mr : (mq && !mr);
    redir = !r && !frz && bt;
    lus   = !r && !frz && !bt && lu;
    e_run = !r && !frz;
    check("pc_en",          pc_en,          e_run && !lus);
    check("if_id_en",       if_id_en,       e_run && !lus);
    check("if_id_flush",    if_id_flush,    r || redir);
    check("id_ex_en",       id_ex_en,       e_run);
    check("id_ex_flush",    id_ex_flush,    r || redir || lus);
    check("ex_mem_en",      ex_mem_en,      e_run);
    check("mem_wb_flush",   mem_wb_flush,   r || frz);
    check("redirect_valid", redirect_valid, redir);
    check("redirect_pc",    redirect_pc,    tgt);
    @(posedge clk);
    if (r) begin
      m_wait = 0; m_waits = 0; m_stalls = 0; m_flushes = 0; m_tout = 0;
    end else begin
      if (!(e_run && !lus) && m_stalls < CMAX) m_stalls++;
      if (redir && m_flushes < CMAX) m_flushes++;
      if (!m_wait) begin
        if (mq && !mr) begin m_wait = 1; m_waits = 0; end
      end else if (mr) begin
        m_wait = 0;
      end else begin
        m_waits++;
        if (m_waits >= MT) m_tout = 1;
      end
    end
    #1;
    check("stall_cycles", {28'b0, stall_cycles}, m_stalls);
    check("flush_count",  {28'b0, flush_count},  m_flushes);
    check("mem_timeout",  mem_timeout,           m_tout);
  endtask

  initial begin
    rst = 1'b1; load_use_stall = 0; ex_branch_taken = 0; ex_branch_tgt = '0;
    mem_req = 0; mem_ready = 0;
    m_wait = 0; m_waits = 0; m_stalls = 0; m_flushes = 0; m_tout = 0;

    // Reset with noisy inputs: controls forced to hold/bubble.
    step(1, 1, 1, 32'hdead_beef, 1, 0);
    step(1, 0, 1, 32'h0000_0040, 1, 1);
    step(0, 0, 0, 32'h0, 0, 0);

    // Single load-use stall.
    step(0, 1, 0, 32'h0, 0, 0);
    check("lu_stall_cycles_is_1", {28'b0, stall_cycles}, 32'd1);

    // Taken branch to 0x100.
    step(0, 0, 1, 32'h100, 0, 0);
    check("branch_flush_count_is_1", {28'b0, flush_count}, 32'd1);

    // Memory wait: ready low three cycles, then completes.
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 1, 1);
    step(0, 0, 0, 32'h0, 0, 0);

    // Zero-wait access, then branch plus load-use in the same cycle.
    step(0, 0, 0, 32'h0, 1, 1);
    step(0, 1, 1, 32'h0000_2000, 0, 0);

    // Branch held during freeze, serviced on release.
    step(0, 0, 1, 32'h0000_3000, 1, 0);
    step(0, 0, 1, 32'h0000_3000, 1, 0);
    step(0, 1, 1, 32'h0000_3000, 1, 1);
    step(0, 0, 0, 32'h0, 0, 0);

    // Timeout: memory never answers; sets after the 4th MEM_WAIT cycle.
    step(0, 0, 0, 32'h0, 1, 0);
    for (int i = 0; i < MT - 1; i++) step(0, 0, 0, 32'h0, 1, 0);
    check("timeout_not_yet", mem_timeout, 1'b0);
    step(0, 0, 0, 32'h0, 1, 0);
    check("timeout_set", mem_timeout, 1'b1);
    step(0, 0, 1, 32'h0000_4000, 0, 0);
    step(0, 0, 0, 32'h0, 0, 0);

    // Reset in the middle of the wait abandons the request.
    step(1, 0, 0, 32'h0, 0, 0);
    check("timeout_cleared", mem_timeout, 1'b0);
    step(0, 0, 0, 32'h0, 0, 0);

    // Stall counter saturation.
    for (int i = 0; i < 20; i++) step(0, 1, 0, 32'h0, 0, 0);
    check("stall_saturates", {28'b0, stall_cycles}, CMAX);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
